exe_issue_wb: RTL
=================

# exe_issue_wb

Issue and writeback wrapper around the single-cycle registered ALU in the execute stage. It accepts decoded ALU operations, reads operands from a 32-entry register file, and drives the ALU inputs with full forwarding. It consumes the ALU's registered result one cycle later and writes it back. No stalls are ever required; one operation can issue per clock.

## Interface
Parameters:
- XLEN, 32, datapath width; must equal the ALU width.
- CLEAR_ON_RESET, 1, when 1 all register file entries are zeroed by reset; when 0 the contents are undefined after reset, except x0.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- op_valid  in  1  upstream op present
- op_ready  out  1  block can accept op
- op_cmd  in  3  ALU command code (ALU_* constants in common)
- op_rs1  in  5  source A register index
- op_rs2  in  5  source B register index
- op_rd  in  5  destination register index
- op_imm  in  XLEN  immediate
- op_use_imm  in  1  1: B operand = op_imm; rs2 ignored
- alu_valid  out  1  to ALU valid
- alu_command  out  3  to ALU command
- alu_in_a  out  XLEN  to ALU in_a
- alu_in_b  out  XLEN  to ALU in_b
- alu_result  in  XLEN  from ALU result (registered in ALU)
- wb_valid  out  1  writeback slot holds a retiring op
- wb_rd  out  5  retiring destination
- wb_data  out  XLEN  retiring value (= alu_result)
- dbg_rs  in  5  debug read index
- dbg_data  out  XLEN  combinational register file read (x0 always 0)

## Operation
- An op is accepted on any rising edge with op_valid && op_ready.
- op_ready = !reset; the block never back-pressures otherwise.
- Pipeline has two tracked slots:
  - Issue register (I): valid, cmd, rd, rs1, rs2, use_imm, opA, opB.
  - Writeback tag (W): valid, rd.
- Each edge, W takes I's valid/rd; I loads the accepted op, or becomes invalid if none is accepted.
- Operand capture into I (read-time bypass):
  - Value = regfile[rs].
  - If W is valid, W.rd == rs, and rs != 0, the value is alu_result instead (covers same-edge write).
  - x0 always reads 0.
  - opB = op_imm when op_use_imm.
- ALU drive (execute-time forward):
  - alu_in_a = alu_result if W is valid, W.rd == I.rs1, and I.rs1 != 0; otherwise I.opA.
  - alu_in_b is the same with rs2, except it is never forwarded when I.use_imm = 1.
- alu_valid = I.valid. When I is invalid:
  - alu_command = ALU_ADD
  - alu_in_a = 0
  - alu_in_b = 0
  - The ALU captures regardless of valid, so results of bubbles are ignored via W.valid.
- Writeback:
  - wb_valid = W.valid, wb_rd = W.rd, wb_data = alu_result.
  - The regfile is written at the edge ending the cycle if W.valid and W.rd != 0.
  - An op with rd = 0 retires with wb_valid = 1 but writes nothing.
- Unknown op_cmd values are passed through unchanged; the ALU default treats them as ADD.

## Timing
- Op accepted at edge E0.
  - Cycle 1: alu_valid = 1.
  - Cycle 2: wb_valid = 1 and wb_data is valid.
  - Written at edge E2; visible on dbg_data in cycle 3.
- Back-to-back dependency (distance 1) is resolved by the execute-time forward.
- Distance 2 is resolved by the read-time bypass.
- Distance ≥ 3 reads the regfile. Zero bubbles in all cases.
- Reset (any cycle, including mid-stream):
  - Next cycle: I.valid = 0, W.valid = 0, alu_valid = 0, wb_valid = 0, wb_rd = 0, alu_command = ALU_ADD, alu_in_a/b = 0.
  - In-flight ops are discarded and never written.
  - An op presented during reset is not accepted.
  - Regfile is zeroed if CLEAR_ON_RESET.
  - ALU result resets to 0, so wb_data = 0.
- First accept is possible on the first edge with reset = 0.

## Structure
- Package common holds:
  - ALU_* command constants (already there).
  - New typedef regidx_t (logic [4:0]).
  - New struct issue_op_t {cmd, rs1, rs2, rd, imm, use_imm}.
- Sub-module exe_regfile:
  - 32×XLEN storage, two combinational read ports plus one debug read port, one synchronous write port.
  - x0 hardwired to 0; implements the reset clear.
- Forwarding muxes and pipeline tags live in the top module.

## Test plan
- Reset then idle: op_ready = 1, alu_valid = 0, wb_valid = 0; dbg_data = 0 for all 32 indices.
- Distance-1 dependency:
  - ADD x1 = x0 + imm 5, then next cycle ADD x2 = x1 + imm 7.
  - Expected: wb (x1, 5) in cycle 2, wb (x2, 12) in cycle 3; dbg x2 = 12.
- Distance-2 dependency:
  - x1 = 5, then an unrelated op on x4, then ADD x3 = x1 + x1 (register operands).
  - Expected: wb (x3, 10).
- All commands with x1 = 0x0000FFFF, x2 = 0x000000FF (register operands):
  - AND → 0xFF
  - OR → 0xFFFF
  - ADD → 0x100FE
  - SUB → 0xFF00
  - XOR → 0xFF00
- x0 handling:
  - XOR rd = 0, imm 0xFFFF_FFFF → wb_valid = 1, wb_rd = 0, dbg x0 = 0.
  - Next op ADD x5 = x0 + imm 1 → wb (x5, 1); no forward from rd = 0.
- Reset mid-stream:
  - Issue x6 = 9 and x7 = 3 on consecutive cycles; assert reset the cycle after x7 is accepted.
  - Expected: no wb_valid for either op; dbg x6 = x7 = 0 (CLEAR_ON_RESET = 1).

Source files
------------

// File: rtl/common.sv
// Shared execute-stage definitions.
//   ALU_*       : 3-bit ALU command codes. The ALU treats any other code as ADD.
//   regidx_t    : architectural register index (x0..x31).
//   issue_op_t  : one decoded ALU operation as presented to the issue stage.
package common;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  // Datapath width of the ALU. Every user of issue_op_t must run at this width.
  localparam int ALU_XLEN = 32;

  typedef logic [4:0] regidx_t;

  typedef struct packed {
    logic [2:0]          cmd;
    regidx_t             rs1;
    regidx_t             rs2;
    regidx_t             rd;
    logic [ALU_XLEN-1:0] imm;
    logic                use_imm;
  } issue_op_t;

endpackage

// File: rtl/exe_regfile.sv
// 32 x XLEN register file for the execute stage.
//   rd_idx_a/rd_data_a, rd_idx_b/rd_data_b : combinational operand reads
//   dbg_idx/dbg_data                       : combinational debug read
//   wr_en/wr_idx/wr_data                   : synchronous write on rising clk
//   reset                                  : synchronous, active-high; zeroes
//                                            all entries when CLEAR_ON_RESET
// x0 always reads 0 and is never stored. Reset has priority over a write.
module exe_regfile
  import common::*;
#(
  parameter int XLEN           = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  regidx_t         rd_idx_a,
  output logic [XLEN-1:0] rd_data_a,
  input  regidx_t         rd_idx_b,
  output logic [XLEN-1:0] rd_data_b,
  input  regidx_t         dbg_idx,
  output logic [XLEN-1:0] dbg_data,
  input  logic            wr_en,
  input  regidx_t         wr_idx,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem [1:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET) begin
        for (int i = 1; i < 32; i++) mem[i] <= '0;
      end
    end else if (wr_en && wr_idx != '0) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data_a = (rd_idx_a == '0) ? '0 : mem[rd_idx_a];
  assign rd_data_b = (rd_idx_b == '0) ? '0 : mem[rd_idx_b];
  assign dbg_data  = (dbg_idx  == '0) ? '0 : mem[dbg_idx];

endmodule

// File: rtl/exe_issue_wb.sv
// Issue / writeback wrapper around the single-cycle registered ALU.
//   op_*        : decoded op in (valid/ready); never back-pressures outside reset
//   alu_*       : drive to the ALU; alu_result is the ALU's registered output
//   wb_*        : retiring op (wb_data is alu_result)
//   dbg_rs/data : combinational register file peek
// Two tracked slots: I (issue register feeding the ALU) and W (tag of the op
// whose result the ALU is presenting this cycle). Dependencies at distance 1
// are forwarded into the ALU inputs; distance 2 is bypassed when operands are
// captured into I, which also covers the write landing on that same edge.
module exe_issue_wb
  import common::*;
#(
  parameter int XLEN           = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_cmd,
  input  logic [4:0]      op_rs1,
  input  logic [4:0]      op_rs2,
  input  logic [4:0]      op_rd,
  input  logic [XLEN-1:0] op_imm,
  input  logic            op_use_imm,
  output logic            alu_valid,
  output logic [2:0]      alu_command,
  output logic [XLEN-1:0] alu_in_a,
  output logic [XLEN-1:0] alu_in_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic [4:0]      dbg_rs,
  output logic [XLEN-1:0] dbg_data
);

  issue_op_t op;
  logic      accept;

  logic            i_valid;
  logic [2:0]      i_cmd;
  regidx_t         i_rs1;
  regidx_t         i_rs2;
  regidx_t         i_rd;
  logic            i_use_imm;
  logic [XLEN-1:0] i_opa;
  logic [XLEN-1:0] i_opb;

  logic    w_valid;
  regidx_t w_rd;

  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic [XLEN-1:0] cap_a;
  logic [XLEN-1:0] cap_b;
  logic            fwd_a;
  logic            fwd_b;

  assign op = '{cmd: op_cmd, rs1: op_rs1, rs2: op_rs2, rd: op_rd,
                imm: op_imm, use_imm: op_use_imm};

  assign op_ready = !reset;
  assign accept   = op_valid && op_ready;

  exe_regfile #(
    .XLEN           (XLEN),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_idx_a  (op.rs1),
    .rd_data_a (rf_a),
    .rd_idx_b  (op.rs2),
    .rd_data_b (rf_b),
    .dbg_idx   (dbg_rs),
    .dbg_data  (dbg_data),
    .wr_en     (w_valid && !reset),
    .wr_idx    (w_rd),
    .wr_data   (alu_result)
  );

  // Read-time bypass: the value being written this edge wins over the array.
  always_comb begin
    cap_a = rf_a;
    cap_b = rf_b;
    if (w_valid && w_rd == op.rs1 && op.rs1 != '0) cap_a = alu_result;
    if (w_valid && w_rd == op.rs2 && op.rs2 != '0) cap_b = alu_result;
    if (op.use_imm) cap_b = op.imm;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_valid   <= 1'b0;
      i_cmd     <= ALU_ADD;
      i_rs1     <= '0;
      i_rs2     <= '0;
      i_rd      <= '0;
      i_use_imm <= 1'b0;
      i_opa     <= '0;
      i_opb     <= '0;
      w_valid   <= 1'b0;
      w_rd      <= '0;
    end else begin
      w_valid <= i_valid;
      w_rd    <= i_rd;
      i_valid <= accept;
      if (accept) begin
        i_cmd     <= op.cmd;
        i_rs1     <= op.rs1;
        i_rs2     <= op.rs2;
        i_rd      <= op.rd;
        i_use_imm <= op.use_imm;
        i_opa     <= cap_a;
        i_opb     <= cap_b;
      end
    end
  end

  // Execute-time forward from the op retiring right now.
  assign fwd_a = w_valid && w_rd == i_rs1 && i_rs1 != '0;
  assign fwd_b = w_valid && w_rd == i_rs2 && i_rs2 != '0 && !i_use_imm;

  always_comb begin
    alu_valid   = i_valid;
    alu_command = ALU_ADD;
    alu_in_a    = '0;
    alu_in_b    = '0;
    if (i_valid) begin
      alu_command = i_cmd;
      alu_in_a    = fwd_a ? alu_result : i_opa;
      alu_in_b    = fwd_b ? alu_result : i_opb;
    end
  end

  // A slot being flushed by reset is not presented as retiring.
  assign wb_valid = w_valid && !reset;
  assign wb_rd    = w_rd;
  assign wb_data  = alu_result;

endmodule
